// File: rtl/lut_logic_pkg.sv
// Shared types and constants for the programmable LUT logic unit.
// Holds the loader state enum and the reset (Q = A) table generator.
package lut_logic_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    // Bit i of the table equals bit k-1 of i, i.e. the output follows input A.
    function automatic logic [63:0] reset_table(input int k);
        logic [63:0] t;
        t = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < (1 << k)) begin
                t[i] = ((i >> (k - 1)) & 1) != 0;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/lut_logic_unit_if.sv
// Handshake, result and table-load signals of the LUT logic unit.
// The ones_count signal exists only when LUT_COUNT_EN is defined.
interface lut_logic_unit_if
    import lut_logic_pkg::*;
#(
    parameter int K  = 3,
    parameter int CH = 4
);

    logic              in_valid;
    logic              in_ready;
    logic [CH*K-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CH-1:0]     out_data;
    logic              load_start;
    logic              load_valid;
    logic              load_bit;
    logic              busy;
`ifdef LUT_COUNT_EN
    logic [CNT_W-1:0]  ones_count;
`endif

    modport master (
        output in_valid, in_data, out_ready,
        output load_start, load_valid, load_bit,
        input  in_ready, out_valid, out_data, busy
`ifdef LUT_COUNT_EN
        , input ones_count
`endif
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        input  load_start, load_valid, load_bit,
        output in_ready, out_valid, out_data, busy
`ifdef LUT_COUNT_EN
        , output ones_count
`endif
    );

endinterface

// File: rtl/lut_logic_unit_loader.sv
// Serial truth-table loader: IDLE/LOAD FSM, shadow register and commit.
// The active table only changes when the final bit of a load is accepted.
module lut_loader
    import lut_logic_pkg::*;
#(
    parameter int K = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_start_i,
    input  logic            load_valid_i,
    input  logic            load_bit_i,
    output logic [2**K-1:0] table_o,
    output logic            busy_o
);

    localparam int N = 2**K;
    localparam logic [63:0]  RST64 = reset_table(K);
    localparam logic [N-1:0] RST   = RST64[N-1:0];
    localparam logic [K-1:0] LAST  = '1;

    state_e         state_q, state_d;
    logic [K-1:0]   cnt_q, cnt_d;
    logic [N-1:0]   shadow_q, shadow_d;
    logic [N-1:0]   table_q, table_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= RST;
            table_q  <= RST;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            table_q  <= table_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        table_d  = table_q;
        unique case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (load_valid_i) begin
                    shadow_d[cnt_q] = load_bit_i;
                    cnt_d           = cnt_q + 1'b1;
                    // Last bit: commit includes the bit arriving this cycle.
                    if (cnt_q == LAST) begin
                        table_d = shadow_d;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign table_o = table_q;
    assign busy_o  = (state_q == LOAD);

endmodule

// File: rtl/lut_logic_unit.sv
// Top of the LUT logic unit: handshake register, per-channel lookups and
// the optional saturating ones counter (enabled by LUT_COUNT_EN).
module lut_logic_unit
    import lut_logic_pkg::*;
#(
    parameter int K  = 3,
    parameter int CH = 4
) (
    input logic             clk,
    input logic             rst_n,
    lut_logic_unit_if.slave bus
);

    localparam int N = 2**K;

    logic [N-1:0]  table_w;
    logic          busy_w;
    logic [CH-1:0] look_w;
    logic [CH-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_w;
    logic          in_fire;
    logic          out_fire;

    lut_loader #(.K(K)) u_loader (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (bus.load_start),
        .load_valid_i (bus.load_valid),
        .load_bit_i   (bus.load_bit),
        .table_o      (table_w),
        .busy_o       (busy_w)
    );

    assign in_ready_w = !busy_w && (!out_valid_q || bus.out_ready);
    assign in_fire    = bus.in_valid && in_ready_w;
    assign out_fire   = out_valid_q && bus.out_ready;

    always_comb begin
        look_w = '0;
        for (int c = 0; c < CH; c++) begin
            look_w[c] = table_w[bus.in_data[c*K +: K]];
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (in_fire) begin
            out_data_d  = look_w;
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_w;

`ifdef LUT_COUNT_EN
    localparam int SW = CNT_W + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   sum_w;

    always_comb begin
        sum_w = {1'b0, cnt_q} + SW'($countones(out_data_q));
        cnt_d = cnt_q;
        if (out_fire) begin
            cnt_d = sum_w[CNT_W] ? '1 : sum_w[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.ones_count = cnt_q;
`endif

endmodule
